// File: rtl/decoder_2x4_pkg.sv
// Shared ALU select encodings and the matching one-hot unit-enable constants.
// The enable for a select value is the MSB-first one-hot position of that select.
package decoder_2x4_pkg;

  typedef enum logic [1:0] {
    FUN_ARITH = 2'b00,
    FUN_LOGIC = 2'b01,
    FUN_CMP   = 2'b10,
    FUN_SHIFT = 2'b11
  } alu_fun_e;

  localparam logic [3:0] EN_ARITH = 4'b1000;
  localparam logic [3:0] EN_LOGIC = 4'b0100;
  localparam logic [3:0] EN_CMP   = 4'b0010;
  localparam logic [3:0] EN_SHIFT = 4'b0001;
  localparam logic [3:0] EN_NONE  = 4'b0000;

endpackage : decoder_2x4_pkg

// File: rtl/decoder_2x4.sv
// ALU function-select decoder: 2-bit ALU_FUN to a one-hot unit enable, MSB-first.
// OUT_REG=0 is purely combinational; OUT_REG=1 registers y with a synchronous reset.
module decoder_2x4
  import decoder_2x4_pkg::*;
#(
  parameter bit OUT_REG = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ALU_FUN,
  output logic [3:0] y
);

  generate
    if (OUT_REG == 1'b0) begin : g_comb
      // Clock and reset have no role in this build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      // An X/Z select matches no item and falls through to the all-zero default.
      always_comb begin
        y = EN_NONE;
        case (ALU_FUN)
          FUN_ARITH: y = EN_ARITH;
          FUN_LOGIC: y = EN_LOGIC;
          FUN_CMP:   y = EN_CMP;
          FUN_SHIFT: y = EN_SHIFT;
          default:   y = EN_NONE;
        endcase
      end
    end else begin : g_reg
      logic [3:0] y_q;

      // Reset wins over decode at the same edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          y_q <= EN_NONE;
        end else begin
          case (ALU_FUN)
            FUN_ARITH: y_q <= EN_ARITH;
            FUN_LOGIC: y_q <= EN_LOGIC;
            FUN_CMP:   y_q <= EN_CMP;
            FUN_SHIFT: y_q <= EN_SHIFT;
            default:   y_q <= EN_NONE;
          endcase
        end
      end

      assign y = y_q;
    end
  endgenerate

endmodule : decoder_2x4

// File: tb/tb_decoder_2x4.sv
// Bench for both builds of decoder_2x4: directed steps, then randomized selects
// against an arithmetic reference (enable = 4'b1000 shifted right by the select).
module tb_decoder_2x4;

  logic       clk_tb;
  logic       rst;
  logic [1:0] fun_c;
  logic [1:0] fun_r;
  logic [3:0] y_c;
  logic [3:0] y_r;

  int checks;
  int errors;
  logic [3:0] exp_r;

  // Clock and reset
  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  decoder_2x4 #(.OUT_REG(1'b0)) dut_comb (
    .clk     (clk_tb),
    .rst     (rst),
    .ALU_FUN (fun_c),
    .y       (y_c)
  );

  decoder_2x4 #(.OUT_REG(1'b1)) dut_reg (
    .clk     (clk_tb),
    .rst     (rst),
    .ALU_FUN (fun_r),
    .y       (y_r)
  );

  // Reference model
  function automatic logic [3:0] ref_dec(input logic [1:0] f);
    if ($isunknown(f)) return 4'b0000;
    return 4'b1000 >> f;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Registered build: expected value is captured from the inputs present at the edge.
  task automatic tick();
    exp_r = rst ? 4'b0000 : ref_dec(fun_r);
    @(posedge clk_tb);
    #1;
  endtask

  initial begin
    logic [1:0] vec [4];
    logic [1:0] xval;
    logic       rst_at_edge;
    checks = 0;
    errors = 0;
    vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b10; vec[3] = 2'b11;
    rst   = 1'b1;
    fun_c = 2'b00;
    fun_r = 2'b00;

    // Reset state; combinational build ignores rst.
    tick();
    check("reset_reg", y_r, 4'b0000);
    check("reset_comb_ignores_rst", y_c, 4'b1000);

    // 1. Combinational decode table
    for (int i = 0; i < 4; i++) begin
      fun_c = vec[i];
      #11;
      check("comb_table", y_c, ref_dec(vec[i]));
    end
    check("comb_table_last", y_c, 4'b0001);

    // 2. Unknown select, then recovery
    xval = 2'bx1;
    fun_c = xval;
    #11;
    check("comb_unknown", y_c, ref_dec(xval));
    fun_c = 2'b01;
    #11;
    check("comb_recover", y_c, 4'b0100);

    // 3. Hold reset with select 11, then release
    rst = 1'b1;
    fun_r = 2'b11;
    tick();
    check("rst_hold_1", y_r, 4'b0000);
    tick();
    check("rst_hold_2", y_r, 4'b0000);
    rst = 1'b0;
    tick();
    check("rst_release", y_r, 4'b0001);

    // 4. Back-to-back select changes, one edge of latency
    for (int i = 0; i < 4; i++) begin
      fun_r = vec[i];
      tick();
      check("reg_step", y_r, exp_r);
    end
    check("reg_step_last", y_r, 4'b0001);

    // 5. Reset asserted mid-operation
    fun_r = 2'b10;
    tick();
    check("reg_pre_rst", y_r, 4'b0010);
    rst = 1'b1;
    tick();
    check("reg_mid_rst", y_r, 4'b0000);
    tick();
    check("reg_rst_held", y_r, 4'b0000);
    rst = 1'b0;

    // 6. Random selects on both builds with occasional resets
    for (int n = 0; n < 1000; n++) begin
      fun_c = 2'($urandom_range(0, 3));
      fun_r = 2'($urandom_range(0, 3));
      rst   = ($urandom_range(0, 19) == 0);
      rst_at_edge = rst;
      tick();
      check("rand_comb", y_c, ref_dec(fun_c));
      check("rand_comb_onehot", 4'($countones(y_c)), 4'd1);
      check("rand_reg", y_r, exp_r);
      if (!rst_at_edge) check("rand_reg_onehot", 4'($countones(y_r)), 4'd1);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decoder_2x4
